sr_request_sequencer: RTL and testbench
=======================================

Name: sr_request_sequencer

Overview:
- Upstream drive stage for the SR flip-flop.
- Takes two raw, asynchronous request lines (set request, clear request). It synchronises and debounces them, then converts each debounced rising edge into a clean, fixed-length S or R pulse.
- Guarantees that S and R are never high together. Simultaneous requests are reported on CONFLICT and produce no output pulse.
- S and R connect directly to the flip-flop's S/R inputs in the same CLK domain.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive cycles the synchronised input must differ from the debounced level before the debounced level flips. Must be ≥1.
- PULSE_LEN, 2: cycles that S or R is held high per accepted request. Must be ≥1.
- GAP_LEN, 1: cycles with S=R=0 forced after each pulse before the next pulse may start. Must be ≥1.

Ports:
- CLK  input  1  system clock; all logic on posedge
- RST  input  1  synchronous, active-high reset
- SET_IN  input  1  raw set request, asynchronous to CLK
- CLR_IN  input  1  raw clear request, asynchronous to CLK
- S  output  1  set pulse to flip-flop, registered
- R  output  1  reset pulse to flip-flop, registered
- BUSY  output  1  high while in DRIVE_S, DRIVE_R or GAP
- CONFLICT  output  1  one-cycle pulse: set and clear requests resolved in the same cycle, both dropped
- OVERRUN  output  1  one-cycle pulse: a request arrived while one of the same direction was already pending, so the new request was dropped

Behaviour:
- Reset:
  - While RST=1 at a posedge, all state clears: sync flops=0, debounced levels=0, counters=0, pending flags=0, FSM=IDLE.
  - S, R, BUSY, CONFLICT and OVERRUN are all 0 at the next edge.
  - RST mid-pulse aborts the pulse immediately; there is no completion and no GAP.
- Synchroniser: two-flop chain per input.
- Debounce (per input):
  - The counter increments each cycle that sync_out != debounced, and clears to 0 the cycle they are equal.
  - When the counter would reach DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Event: a debounced 0->1 transition is a one-cycle internal event. Falling transitions are ignored.
- Latency: with SET_IN held high from edge k, S is first high at edge k+DEBOUNCE_CYCLES+3. CLR_IN/R behave the same.
- Pending flags pend_s and pend_r:
  - An event sets its flag.
  - If the flag is already set, or the FSM is already driving that same direction, the event is dropped and OVERRUN pulses.
- FSM states: IDLE, DRIVE_S, DRIVE_R, GAP.
  - IDLE, pend_s only: go to DRIVE_S, clear pend_s.
  - IDLE, pend_r only: go to DRIVE_R, clear pend_r.
  - IDLE, pend_s and pend_r both set, or both events in the same cycle: clear both, pulse CONFLICT, stay IDLE.
  - Events arriving in IDLE are evaluated in the same cycle they occur, so an event-to-S latency of 1 cycle applies.
  - DRIVE_S: S=1 for exactly PULSE_LEN cycles, then GAP. DRIVE_R is the same with R.
  - GAP: S=R=0 for exactly GAP_LEN cycles, then IDLE. Pending flags are evaluated on the IDLE cycle.
- Invariants:
  - S&R==0 in every cycle.
  - S and R are functions of registered state only.
- Counters are sized $clog2(param+1). No wrap occurs: every counter clears on terminal count.
- Events arriving during DRIVE/GAP are held pending, at most one per direction. A pend_s set during DRIVE_R is served after GAP.

Test Plan:
1. Reset, then SET_IN=1 held from edge 10 (defaults 4/2/1) -> S high at edges 17–18, BUSY high 17–19 (3 cycles), R=0 throughout.
2. SET_IN glitch high for 3 cycles, then low -> S, R, CONFLICT and OVERRUN all stay 0; debounced level unchanged.
3. SET_IN and CLR_IN rise on the same edge and are held -> CONFLICT pulses for exactly 1 cycle; S=R=0; BUSY=0.
4. CLR_IN rises, then SET_IN rises so that its event lands during DRIVE_R -> R high 2 cycles, 1 gap cycle, then S high 2 cycles; S&R never both 1; CONFLICT=0.
5. During DRIVE_S, toggle CLR_IN so two debounced clear events occur -> first is held pending and served as an R pulse after GAP; second pulses OVERRUN once.
6. Assert RST for 1 cycle during the second cycle of an S pulse -> S=0 at the next edge; BUSY=0; a following fresh request behaves as in scenario 1.

Source files
------------

// File: rtl/sr_request_sequencer.sv
// sr_request_sequencer: synchronises and debounces raw set/clear requests and turns each
// debounced rising edge into a fixed-length S or R pulse, never both, with a forced gap.
module sr_request_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_LEN = 2,
    parameter int GAP_LEN = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic SET_IN,
    input  logic CLR_IN,
    output logic S,
    output logic R,
    output logic BUSY,
    output logic CONFLICT,
    output logic OVERRUN
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PMAX = PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN;
    localparam int CW = $clog2(PMAX + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] P_LAST = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] G_LAST = CW'(GAP_LEN - 1);

    typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, GAP} state_t;

    state_t state;
    logic [1:0] sync1, sync2, deb, deb_d, ev;
    logic [DW-1:0] dcnt [2];
    logic [CW-1:0] cnt;
    logic pend_s, pend_r, want_s, want_r, ovr_s, ovr_r;

    // bit 0 carries the set request, bit 1 the clear request
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= '0;
            sync2 <= '0;
            deb <= '0;
            deb_d <= '0;
            dcnt <= '{default: '0};
        end else begin
            sync1 <= {CLR_IN, SET_IN};
            sync2 <= sync1;
            deb_d <= deb;
            for (int i = 0; i < 2; i++) begin
                dcnt[i] <= (sync2[i] == deb[i] || dcnt[i] == D_LAST) ? '0 : dcnt[i] + 1'b1;
                if (sync2[i] != deb[i] && dcnt[i] == D_LAST)
                    deb[i] <= ~deb[i];
            end
        end
    end

    always_comb begin
        ev = deb & ~deb_d;
        want_s = pend_s | ev[0];
        want_r = pend_r | ev[1];
        ovr_s = ev[0] & (pend_s | (state == DRIVE_S));
        ovr_r = ev[1] & (pend_r | (state == DRIVE_R));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            pend_s <= 1'b0;
            pend_r <= 1'b0;
            S <= 1'b0;
            R <= 1'b0;
            BUSY <= 1'b0;
            CONFLICT <= 1'b0;
            OVERRUN <= 1'b0;
        end else begin
            CONFLICT <= 1'b0;
            OVERRUN <= ovr_s | ovr_r;
            // while busy, at most one request per direction is held for later
            if (state != IDLE) begin
                if (ev[0] && !ovr_s)
                    pend_s <= 1'b1;
                if (ev[1] && !ovr_r)
                    pend_r <= 1'b1;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (want_s && want_r) begin
                        CONFLICT <= 1'b1;
                        pend_s <= 1'b0;
                        pend_r <= 1'b0;
                    end else if (want_s) begin
                        state <= DRIVE_S;
                        S <= 1'b1;
                        BUSY <= 1'b1;
                        pend_s <= 1'b0;
                    end else if (want_r) begin
                        state <= DRIVE_R;
                        R <= 1'b1;
                        BUSY <= 1'b1;
                        pend_r <= 1'b0;
                    end
                end
                DRIVE_S, DRIVE_R: begin
                    cnt <= cnt == P_LAST ? '0 : cnt + 1'b1;
                    if (cnt == P_LAST) begin
                        state <= GAP;
                        S <= 1'b0;
                        R <= 1'b0;
                    end
                end
                default: begin
                    cnt <= cnt == G_LAST ? '0 : cnt + 1'b1;
                    if (cnt == G_LAST) begin
                        state <= IDLE;
                        BUSY <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sr_request_sequencer.sv
// tb_sr_request_sequencer: directed scenarios and random requests against a cycle model
// for a default instance and a long-pulse instance driven from the same inputs.
module tb_sr_request_sequencer;
    localparam logic [7:0] D0 = 8'd4, P0 = 8'd2, G0 = 8'd1;
    localparam logic [7:0] D1 = 8'd2, P1 = 8'd20, G1 = 8'd2;

    typedef struct packed {
        logic [1:0] sa, sb, lvl, lvlp;
        logic [1:0][7:0] run;
        logic ps, pr;
        logic [1:0] dir;
        logic [7:0] left;
        logic [4:0] exp;
    } mdl_t;

    logic clk = 1'b0, rst = 1'b1, set_in = 1'b0, clr_in = 1'b0;
    logic s0, r0, b0, c0, v0, s1, r1, b1, c1, v1;
    logic [4:0] o0, o1;
    int checks = 0, passes = 0, cyc = 0;
    mdl_t m0, m1;

    assign o0 = {s0, r0, b0, c0, v0};
    assign o1 = {s1, r1, b1, c1, v1};

    always #5 clk = ~clk;

    sr_request_sequencer u0 (
        .CLK(clk), .RST(rst), .SET_IN(set_in), .CLR_IN(clr_in),
        .S(s0), .R(r0), .BUSY(b0), .CONFLICT(c0), .OVERRUN(v0)
    );

    sr_request_sequencer #(.DEBOUNCE_CYCLES(2), .PULSE_LEN(20), .GAP_LEN(2)) u1 (
        .CLK(clk), .RST(rst), .SET_IN(set_in), .CLR_IN(clr_in),
        .S(s1), .R(r1), .BUSY(b1), .CONFLICT(c1), .OVERRUN(v1)
    );

    // one clock edge of the behaviour: busy time is a single countdown of pulse+gap cycles
    function automatic mdl_t step(mdl_t m, logic rs, logic si, logic ci,
                                  logic [7:0] d, logic [7:0] p, logic [7:0] g);
        mdl_t n;
        logic es, er, conf, ovr;
        n = m;
        conf = 1'b0;
        ovr = 1'b0;
        if (rs) return '0;
        es = m.lvl[0] & ~m.lvlp[0];
        er = m.lvl[1] & ~m.lvlp[1];
        if (m.left == 8'd0) begin
            ovr = (es & m.ps) | (er & m.pr);
            if ((m.ps | es) & (m.pr | er)) begin
                conf = 1'b1;
                n.ps = 1'b0;
                n.pr = 1'b0;
            end else if (m.ps | es) begin
                n.dir = 2'd1;
                n.left = p + g;
                n.ps = 1'b0;
            end else if (m.pr | er) begin
                n.dir = 2'd2;
                n.left = p + g;
                n.pr = 1'b0;
            end
        end else begin
            if (es) begin
                if (m.ps | (m.dir == 2'd1 && m.left > g)) ovr = 1'b1;
                else n.ps = 1'b1;
            end
            if (er) begin
                if (m.pr | (m.dir == 2'd2 && m.left > g)) ovr = 1'b1;
                else n.pr = 1'b1;
            end
            n.left = m.left - 8'd1;
        end
        n.lvlp = m.lvl;
        for (int c = 0; c < 2; c++) begin
            if (m.sb[c] == m.lvl[c]) n.run[c] = 8'd0;
            else if (m.run[c] + 8'd1 == d) begin
                n.run[c] = 8'd0;
                n.lvl[c] = ~m.lvl[c];
            end else n.run[c] = m.run[c] + 8'd1;
        end
        n.sb = m.sa;
        n.sa = {ci, si};
        n.exp = {n.dir == 2'd1 && n.left > g, n.dir == 2'd2 && n.left > g, n.left != 8'd0, conf, ovr};
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        m0 = step(m0, rst, set_in, clr_in, D0, P0, G0);
        m1 = step(m1, rst, set_in, clr_in, D1, P1, G1);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; set_in = 1'b1; clr_in = 1'b1;
        for (int t = 0; t < 4; t++) begin
            tick();
            checks += 2;
            if (o0 !== 5'b0) $display("FAIL reset u0: got %b want 00000", o0); else passes++;
            if (o1 !== 5'b0) $display("FAIL reset u1: got %b want 00000", o1); else passes++;
        end
        rst = 1'b0; set_in = 1'b0; clr_in = 1'b0;
        for (int t = 0; t < 10; t++) begin
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL reset_idle u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL reset_idle u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
        end
    endtask

    task automatic test_single_set();
        int fs = -1, fb = -1, sc = 0, bc = 0, rc = 0;
        for (int t = 0; t < 70; t++) begin
            set_in = t >= 10 && t < 30;
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL single_set u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL single_set u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            if (s0 && fs < 0) fs = t + 1;
            if (b0 && fb < 0) fb = t + 1;
            sc += int'(s0); bc += int'(b0); rc += int'(r0);
        end
        checks += 5;
        if (fs !== 17) $display("FAIL single_set first_s: got %0d want 17", fs); else passes++;
        if (sc !== 2) $display("FAIL single_set s_cycles: got %0d want 2", sc); else passes++;
        if (fb !== 17) $display("FAIL single_set first_busy: got %0d want 17", fb); else passes++;
        if (bc !== 3) $display("FAIL single_set busy_cycles: got %0d want 3", bc); else passes++;
        if (rc !== 0) $display("FAIL single_set r_cycles: got %0d want 0", rc); else passes++;
    endtask

    task automatic test_glitch();
        int act = 0;
        for (int t = 0; t < 40; t++) begin
            set_in = t >= 5 && t < 8;
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL glitch u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL glitch u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            act += int'(|o0);
        end
        checks++;
        if (act !== 0) $display("FAIL glitch u0_active_cycles: got %0d want 0", act); else passes++;
    endtask

    task automatic test_conflict();
        int cc0 = 0, cc1 = 0, oth = 0;
        for (int t = 0; t < 50; t++) begin
            set_in = t >= 5 && t < 30;
            clr_in = set_in;
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL conflict u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL conflict u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            cc0 += int'(c0); cc1 += int'(c1);
            oth += int'(s0 | r0 | b0 | s1 | r1 | b1);
        end
        checks += 3;
        if (cc0 !== 1) $display("FAIL conflict u0_pulses: got %0d want 1", cc0); else passes++;
        if (cc1 !== 1) $display("FAIL conflict u1_pulses: got %0d want 1", cc1); else passes++;
        if (oth !== 0) $display("FAIL conflict drive_cycles: got %0d want 0", oth); else passes++;
    endtask

    task automatic test_back_to_back();
        int fs = -1, fr = -1, sc = 0, rc = 0, both = 0, cc = 0;
        for (int t = 0; t < 80; t++) begin
            clr_in = t >= 5 && t < 25;
            set_in = t >= 6 && t < 25;
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL back_to_back u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL back_to_back u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            if (s0 && fs < 0) fs = t + 1;
            if (r0 && fr < 0) fr = t + 1;
            sc += int'(s0); rc += int'(r0);
            both += int'((s0 & r0) | (s1 & r1));
            cc += int'(c0 | c1);
        end
        checks += 5;
        if (rc !== 2) $display("FAIL back_to_back r_cycles: got %0d want 2", rc); else passes++;
        if (sc !== 2) $display("FAIL back_to_back s_cycles: got %0d want 2", sc); else passes++;
        if (fs - fr !== 4) $display("FAIL back_to_back r_to_s: got %0d want 4", fs - fr); else passes++;
        if (both !== 0) $display("FAIL back_to_back s_and_r: got %0d want 0", both); else passes++;
        if (cc !== 0) $display("FAIL back_to_back conflicts: got %0d want 0", cc); else passes++;
    endtask

    task automatic test_overrun();
        int fs = -1, fr = -1, rc0 = 0, rc1 = 0, vc0 = 0, vc1 = 0;
        for (int t = 0; t < 90; t++) begin
            set_in = t >= 5 && t < 60;
            clr_in = (t >= 6 && t < 12) || (t >= 18 && t < 24);
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL overrun u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL overrun u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            if (s0 && fs < 0) fs = t + 1;
            if (r0 && fr < 0) fr = t + 1;
            rc0 += int'(r0); rc1 += int'(r1); vc0 += int'(v0); vc1 += int'(v1);
        end
        checks += 5;
        if (fr - fs !== 4) $display("FAIL overrun u0_s_to_r: got %0d want 4", fr - fs); else passes++;
        if (rc0 !== 4) $display("FAIL overrun u0_r_cycles: got %0d want 4", rc0); else passes++;
        if (vc0 !== 0) $display("FAIL overrun u0_pulses: got %0d want 0", vc0); else passes++;
        if (vc1 !== 1) $display("FAIL overrun u1_pulses: got %0d want 1", vc1); else passes++;
        if (rc1 !== 20) $display("FAIL overrun u1_r_cycles: got %0d want 20", rc1); else passes++;
    endtask

    task automatic test_reset_mid_pulse();
        int fs = -1, sc = 0, bc = 0, early = 0;
        for (int t = 0; t < 80; t++) begin
            rst = t == 12;
            set_in = (t >= 5 && t < 13) || (t >= 40 && t < 60);
            tick();
            checks += 2;
            if (o0 !== m0.exp) $display("FAIL reset_mid u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL reset_mid u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            if (t + 1 == 13) begin
                checks++;
                if (o0 !== 5'b0) $display("FAIL reset_mid abort: got %b want 00000", o0); else passes++;
            end
            if (t + 1 <= 20) early += int'(s0);
            else begin
                if (s0 && fs < 0) fs = t + 1;
                sc += int'(s0); bc += int'(b0);
            end
        end
        rst = 1'b0;
        checks += 4;
        if (early !== 1) $display("FAIL reset_mid aborted_s_cycles: got %0d want 1", early); else passes++;
        if (fs !== 47) $display("FAIL reset_mid fresh_first_s: got %0d want 47", fs); else passes++;
        if (sc !== 2) $display("FAIL reset_mid fresh_s_cycles: got %0d want 2", sc); else passes++;
        if (bc !== 3) $display("FAIL reset_mid fresh_busy_cycles: got %0d want 3", bc); else passes++;
    endtask

    task automatic test_random();
        int hs = 0, hc = 0;
        for (int t = 0; t < 1500; t++) begin
            if (hs <= 0) begin set_in = 1'($urandom_range(0, 1)); hs = int'($urandom_range(1, 10)); end
            if (hc <= 0) begin clr_in = 1'($urandom_range(0, 1)); hc = int'($urandom_range(1, 10)); end
            rst = $urandom_range(0, 299) == 0;
            hs--; hc--;
            tick();
            checks += 3;
            if (o0 !== m0.exp) $display("FAIL random u0 cyc %0d: got %b want %b", cyc, o0, m0.exp); else passes++;
            if (o1 !== m1.exp) $display("FAIL random u1 cyc %0d: got %b want %b", cyc, o1, m1.exp); else passes++;
            if (((s0 & r0) | (s1 & r1)) !== 1'b0) $display("FAIL random s_and_r cyc %0d: got 1 want 0", cyc); else passes++;
        end
        rst = 1'b0; set_in = 1'b0; clr_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_set();
        test_glitch();
        test_conflict();
        test_back_to_back();
        test_overrun();
        test_reset_mid_pulse();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
